cronometro_ctrl: RTL and testbench
==================================

Name: cronometro_ctrl

Overview:
Run/pause/clear controller for the stopwatch display chain. It divides the system clock into a 1 Hz count tick. It sequences four cascaded BCD digit counters for MM:SS: seconds units, seconds tens, minutes units and minutes tens. The BCD digits it outputs feed the per-digit 7-segment decoders, including the tens-of-minutes decoder.

Parameters:
TICK_DIV, 50000000, clock cycles per count tick; legal range ≥2; benches use 4.
SEC_TENS_MAX, 5, last value of the seconds-tens digit.
MIN_TENS_MAX, 5, last value of the minutes-tens digit.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RST_N  input  1  reset; asynchronous, active-low.
BTN_START  input  1  start/stop button; level, already synchronised and debounced.
BTN_CLEAR  input  1  clear button; level, already synchronised and debounced.
SU  output  4  seconds units, BCD 0-9.
ST  output  4  seconds tens, BCD 0-SEC_TENS_MAX.
MU  output  4  minutes units, BCD 0-9.
MT  output  4  minutes tens, BCD 0-MIN_TENS_MAX.
RUNNING  output  1  high while in state RUN.
WRAP  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Behaviour:
- Reset (RST_N=0, async): state=IDLE; prescaler=0; SU/ST/MU/MT=0; RUNNING=0; WRAP=0; button edge registers=0.
- Buttons: a press is a rising edge of the registered level (prev=0, now=1). Holding a button gives exactly one event. A button held high through reset release gives no event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start event -> RUN.
  - RUN + start event -> PAUSE.
  - PAUSE + start event -> RUN.
  - IDLE or PAUSE + clear event -> IDLE; digits=0 and prescaler=0 on the same edge.
  - Clear event in RUN is ignored.
  - Simultaneous start and clear events:
    - RUN: start wins -> PAUSE; clear is dropped.
    - PAUSE: clear wins -> IDLE.
    - IDLE: clear wins -> stays IDLE.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. It holds its value in PAUSE, so a resumed second keeps its partial progress. It is forced to 0 in IDLE.
  - tick = RUN && prescaler==TICK_DIV-1.
  - On tick the prescaler returns to 0.
- Digit cascade, evaluated on tick only:
  - SU increments; 9 -> 0 carries to ST.
  - ST: SEC_TENS_MAX -> 0 carries to MU.
  - MU: 9 -> 0 carries to MT.
  - MT: MIN_TENS_MAX -> 0 sets WRAP=1 for that single cycle.
  - Counting continues after a wrap; the stopwatch does not stop.
- Latency: the digits change on the clock edge where tick is true. They are visible one cycle after prescaler==TICK_DIV-1 is observed.
- Entering PAUSE on the same edge as a tick: the tick's increment is applied, then the FSM holds.
- RUNNING is registered and equals (state==RUN).
- A digit never holds a value above its max. Out-of-range values cannot arise from reset or from counting.

Optional Feature:
- Macro: CRONOMETRO_LAP_EN. It adds input BTN_LAP (level, same conditioning as the other buttons) and output LAP_ACTIVE.
- With the macro:
  - A BTN_LAP rising edge in RUN toggles lap-hold.
  - While held, SU/ST/MU/MT show the digits captured at the press. The internal counters keep running.
  - The next lap edge releases the hold. The display returns to live digits on the following cycle.
  - Lap edges in IDLE or PAUSE are ignored.
  - A clear event also drops the hold.
  - LAP_ACTIVE = hold flag; reset value 0.
- Without the macro: no port, no capture registers; the outputs always show live digits.

Decomposition:
- Package cronometro_pkg contains:
  - the state enum (IDLE, RUN, PAUSE);
  - the BCD digit width, 4;
  - the default max constants (9, 5).
- Sub-module bcd_digit: parameter MAX; inputs CLK, RST_N, clr, en; outputs q[3:0] and carry.
  - carry = en && q==MAX.
  - Instantiated four times with en chained from carry.
- FSM, prescaler and edge detection stay in cronometro_ctrl.

Test Plan (TICK_DIV=4):
- Reset, then a start press: RUNNING=1 the next cycle. Digits read 00:01 after 4 cycles in RUN and 00:10 after 40 cycles.
- Start; stop at prescaler=2; wait 20 cycles; start: the digits stay frozen during the pause. SU increments 1 cycle after resume.
- Run to 00:09 then one more tick -> SU=0, ST=1. Run from 00:59 -> SU=0, ST=0, MU=1.
- Preload by running to 59:59, one more tick -> all digits 0, WRAP high exactly 1 cycle, RUNNING stays 1.
- Clear press in RUN -> ignored. Pause, then clear and start pressed in the same cycle -> IDLE, digits 00:00, RUNNING=0.
- Assert RST_N=0 mid-count between clock edges -> all outputs 0 immediately. Hold BTN_START high across reset release -> no start event.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch controller.
// Digit width and default per-digit rollover values.
package cronometro_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int DIGIT_W   = 4;
   localparam int UNITS_MAX = 9;
   localparam int TENS_MAX  = 5;

endpackage

// File: rtl/cronometro_ctrl_bcd_digit.sv
// One BCD counter stage: counts 0..MAX on en, wraps to 0, and flags carry.
// Latency: q updates on the enabling edge; carry is combinational. No backpressure.
module bcd_digit
   import cronometro_pkg::*;
#(
   parameter int MAX = UNITS_MAX
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               clr,
   input  logic               en,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);

   localparam logic [DIGIT_W-1:0] QMAX = DIGIT_W'(MAX);

   assign carry = en && (q == QMAX);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= (q == QMAX) ? '0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch run/pause/clear controller: prescaler tick, MM:SS BCD cascade, button FSM.
// Latency: digits change on the tick edge; buttons act on the edge that sees them. No backpressure.
// Optional lap-hold display is enabled by defining CRONOMETRO_LAP_EN.
module cronometro_ctrl
   import cronometro_pkg::*;
#(
   parameter int TICK_DIV     = 50000000,
   parameter int SEC_TENS_MAX = TENS_MAX,
   parameter int MIN_TENS_MAX = TENS_MAX
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               BTN_START,
   input  logic               BTN_CLEAR,
`ifdef CRONOMETRO_LAP_EN
   input  logic               BTN_LAP,
   output logic               LAP_ACTIVE,
`endif
   output logic [DIGIT_W-1:0] SU,
   output logic [DIGIT_W-1:0] ST,
   output logic [DIGIT_W-1:0] MU,
   output logic [DIGIT_W-1:0] MT,
   output logic               RUNNING,
   output logic               WRAP
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t            state, state_nxt;
   logic [PW-1:0]     presc;
   logic              start_q, clear_q, armed;
   logic              start_ev, clear_ev;
   logic              tick, clr_digits;
   logic              su_c, st_c, mu_c, mt_c;
   logic [DIGIT_W-1:0] su_q, st_q, mu_q, mt_q;

   // armed stays low for the first edge after reset so a button held through
   // reset release is absorbed into the previous-level register, not seen as a press
   assign start_ev = armed && BTN_START && !start_q;
   assign clear_ev = armed && BTN_CLEAR && !clear_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         start_q <= 1'b0;
         clear_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         start_q <= BTN_START;
         clear_q <= BTN_CLEAR;
         armed   <= 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      clr_digits = 1'b0;
      case (state)
         IDLE: begin
            if (clear_ev) begin
               clr_digits = 1'b1;
            end else if (start_ev) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (start_ev) state_nxt = PAUSE;
         end
         PAUSE: begin
            if (clear_ev) begin
               state_nxt  = IDLE;
               clr_digits = 1'b1;
            end else if (start_ev) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         RUNNING <= 1'b0;
      end else begin
         state   <= state_nxt;
         RUNNING <= (state_nxt == RUN);
      end
   end

   assign tick = (state == RUN) && (presc == PRESC_LAST);

   // prescaler keeps partial progress across a pause
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
      end else if (state == IDLE || clr_digits) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   bcd_digit #(.MAX(UNITS_MAX)) u_su (
      .CLK(CLK), .RST_N(RST_N), .clr(clr_digits), .en(tick), .q(su_q), .carry(su_c)
   );
   bcd_digit #(.MAX(SEC_TENS_MAX)) u_st (
      .CLK(CLK), .RST_N(RST_N), .clr(clr_digits), .en(su_c), .q(st_q), .carry(st_c)
   );
   bcd_digit #(.MAX(UNITS_MAX)) u_mu (
      .CLK(CLK), .RST_N(RST_N), .clr(clr_digits), .en(st_c), .q(mu_q), .carry(mu_c)
   );
   bcd_digit #(.MAX(MIN_TENS_MAX)) u_mt (
      .CLK(CLK), .RST_N(RST_N), .clr(clr_digits), .en(mu_c), .q(mt_q), .carry(mt_c)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         WRAP <= 1'b0;
      end else begin
         WRAP <= mt_c;
      end
   end

`ifdef CRONOMETRO_LAP_EN
   logic               lap_q, lap_ev, hold;
   logic [DIGIT_W-1:0] su_cap, st_cap, mu_cap, mt_cap;

   assign lap_ev = armed && BTN_LAP && !lap_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lap_q  <= 1'b0;
         hold   <= 1'b0;
         su_cap <= '0;
         st_cap <= '0;
         mu_cap <= '0;
         mt_cap <= '0;
      end else begin
         lap_q <= BTN_LAP;
         if (clear_ev) begin
            hold <= 1'b0;
         end else if (lap_ev && state == RUN) begin
            hold <= !hold;
            if (!hold) begin
               su_cap <= su_q;
               st_cap <= st_q;
               mu_cap <= mu_q;
               mt_cap <= mt_q;
            end
         end
      end
   end

   assign LAP_ACTIVE = hold;
   assign SU = hold ? su_cap : su_q;
   assign ST = hold ? st_cap : st_q;
   assign MU = hold ? mu_cap : mu_q;
   assign MT = hold ? mt_cap : mt_q;
`else
   assign SU = su_q;
   assign ST = st_q;
   assign MU = mu_q;
   assign MT = mt_q;
`endif

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with TICK_DIV=4; digits compared as {MT,MU,ST,SU}.
module tb_cronometro_ctrl;

   logic       clk;
   logic       rst_n;
   logic       btn_start;
   logic       btn_clear;
   logic [3:0] su, st, mu, mt;
   logic       running, wrap;
   logic [15:0] mmss;

   int compared   = 0;
   int mismatched = 0;

   cronometro_ctrl #(
      .TICK_DIV(4)
   ) dut (
      .CLK(clk),
      .RST_N(rst_n),
      .BTN_START(btn_start),
      .BTN_CLEAR(btn_clear),
      .SU(su),
      .ST(st),
      .MU(mu),
      .MT(mt),
      .RUNNING(running),
      .WRAP(wrap)
   );

   assign mmss = {mt, mu, st, su};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_start = 1'b0;
      btn_clear = 1'b0;
      step(2);
      check("rst_digits", mmss, 16'h0000);
      check("rst_running", {15'd0, running}, 16'd0);
      check("rst_wrap", {15'd0, wrap}, 16'd0);
      rst_n = 1'b1;
      step(1);

      // start from reset
      btn_start = 1'b1;
      step(1);
      check("start_running", {15'd0, running}, 16'd1);
      check("start_digits0", mmss, 16'h0000);
      btn_start = 1'b0;
      step(3);
      check("before_first_tick", mmss, 16'h0000);
      step(1);
      check("first_tick_0001", mmss, 16'h0001);
      step(36);
      check("forty_cycles_0010", mmss, 16'h0010);

      // pause with prescaler at 2, wait, resume
      step(2);
      btn_start = 1'b1;
      step(1);
      check("pause_running", {15'd0, running}, 16'd0);
      check("pause_digits", mmss, 16'h0010);
      btn_start = 1'b0;
      step(20);
      check("pause_frozen", mmss, 16'h0010);
      btn_start = 1'b1;
      step(1);
      check("resume_running", {15'd0, running}, 16'd1);
      check("resume_same_edge", mmss, 16'h0010);
      btn_start = 1'b0;
      step(1);
      check("resume_tick_next", mmss, 16'h0011);

      // seconds units and tens carries
      step(32);
      check("at_0019", mmss, 16'h0019);
      step(4);
      check("carry_0020", mmss, 16'h0020);
      step(156);
      check("at_0059", mmss, 16'h0059);
      step(4);
      check("carry_0100", mmss, 16'h0100);

      // full rollover
      step(14156);
      check("at_5959", mmss, 16'h5959);
      check("wrap_low_before", {15'd0, wrap}, 16'd0);
      step(3);
      check("still_5959", mmss, 16'h5959);
      step(1);
      check("rollover_0000", mmss, 16'h0000);
      check("wrap_pulse", {15'd0, wrap}, 16'd1);
      check("running_after_wrap", {15'd0, running}, 16'd1);
      step(1);
      check("wrap_one_cycle", {15'd0, wrap}, 16'd0);

      // clear in RUN is ignored
      btn_clear = 1'b1;
      step(1);
      check("clear_in_run_running", {15'd0, running}, 16'd1);
      btn_clear = 1'b0;
      step(2);
      check("clear_in_run_counting", mmss, 16'h0001);

      // pause, then start+clear together -> IDLE
      btn_start = 1'b1;
      step(1);
      check("pause2_running", {15'd0, running}, 16'd0);
      check("pause2_digits", mmss, 16'h0001);
      btn_start = 1'b0;
      step(1);
      btn_start = 1'b1;
      btn_clear = 1'b1;
      step(1);
      check("both_running", {15'd0, running}, 16'd0);
      check("both_digits", mmss, 16'h0000);
      btn_start = 1'b0;
      btn_clear = 1'b0;
      step(1);

      // restart after clear: prescaler must start from 0
      btn_start = 1'b1;
      step(1);
      check("restart_running", {15'd0, running}, 16'd1);
      btn_start = 1'b0;
      step(3);
      check("restart_no_tick_yet", mmss, 16'h0000);
      step(1);
      check("restart_tick", mmss, 16'h0001);

      // async reset between clock edges
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_digits", mmss, 16'h0000);
      check("async_running", {15'd0, running}, 16'd0);
      check("async_wrap", {15'd0, wrap}, 16'd0);

      // start held high through reset release
      btn_start = 1'b1;
      step(1);
      rst_n = 1'b1;
      step(3);
      check("held_start_no_event", {15'd0, running}, 16'd0);
      check("held_start_digits", mmss, 16'h0000);
      btn_start = 1'b0;
      step(1);
      btn_start = 1'b1;
      step(1);
      check("fresh_press_after_reset", {15'd0, running}, 16'd1);
      btn_start = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
